// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine programme controller:
// state codes, default phase durations and the per-phase duration lookup.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WASH  = 3'd1,
        ST_RINSE = 3'd2,
        ST_DRY   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } wash_state_e;

    localparam int TIMER_W_DEF   = 7;
    localparam int WASH_MIN_DEF  = 30;
    localparam int RINSE_MIN_DEF = 30;
    localparam int DRY_MIN_DEF   = 45;

    // Non-phase states return 1 so the derived terminal limit is always 0.
    function automatic int phase_dur(input wash_state_e s, input int wash_min,
                                     input int rinse_min, input int dry_min);
        case (s)
            ST_WASH:  return wash_min;
            ST_RINSE: return rinse_min;
            ST_DRY:   return dry_min;
            default:  return 1;
        endcase
    endfunction

    function automatic logic is_active(input wash_state_e s);
        return (s == ST_WASH) || (s == ST_RINSE) || (s == ST_DRY);
    endfunction

    function automatic wash_state_e next_phase(input wash_state_e s);
        case (s)
            ST_WASH:  return ST_RINSE;
            ST_RINSE: return ST_DRY;
            ST_DRY:   return ST_DONE;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/wash_cycle_sequencer_min_counter.sv
// Minute counter: clears, counts enabled ticks, flags when it sits on a loaded
// limit, and can optionally saturate at all-ones instead of wrapping.
module min_counter
    import wash_pkg::*;
#(
    parameter int W = TIMER_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic         tick_i,
    input  logic         sat_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = (count_q == {W{1'b1}});

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && tick_i && !(sat_i && at_max)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == limit_i);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash/rinse/dry programme controller with door interlock, pause and abort.
// All outputs are registered; phase reports the current state code.
module wash_cycle_sequencer
    import wash_pkg::*;
#(
    parameter int TIMER_W   = TIMER_W_DEF,
    parameter int WASH_MIN  = WASH_MIN_DEF,
    parameter int RINSE_MIN = RINSE_MIN_DEF,
    parameter int DRY_MIN   = DRY_MIN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_min,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic               door_closed,
    output logic               water,
    output logic               detergent,
    output logic               spin,
    output logic               door_lock,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [2:0]         phase,
    output logic [TIMER_W-1:0] elapsed
);

    wash_state_e        state_q, state_d;
    logic               water_q, detergent_q, spin_q, door_lock_q, busy_q, done_q, fault_q;
    logic               active_q;
    logic               start_ok;
    logic               count_en;
    logic               advance;
    logic               paused_now;
    logic               phase_term;
    logic [TIMER_W-1:0] phase_limit;
    logic [TIMER_W-1:0] unused_phase_cnt;
    logic               unused_elapsed_term;

    assign active_q    = is_active(state_q);
    assign start_ok    = (state_q == ST_IDLE) && start && door_closed;
    // Abort and door-open both outrank pause and tick, so they also block counting.
    assign count_en    = active_q && !abort && door_closed && !pause;
    assign advance     = count_en && tick_min && phase_term;
    assign paused_now  = active_q && pause;
    assign phase_limit = TIMER_W'(phase_dur(state_q, WASH_MIN, RINSE_MIN, DRY_MIN) - 1);

    min_counter #(.W(TIMER_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (start_ok || advance || (active_q && abort)),
        .enable_i (count_en),
        .tick_i   (tick_min),
        .sat_i    (1'b0),
        .limit_i  (phase_limit),
        .count_o  (unused_phase_cnt),
        .term_o   (phase_term)
    );

    min_counter #(.W(TIMER_W)) u_elapsed_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (start_ok),
        .enable_i (count_en),
        .tick_i   (tick_min),
        .sat_i    (1'b1),
        .limit_i  ({TIMER_W{1'b1}}),
        .count_o  (elapsed),
        .term_o   (unused_elapsed_term)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_WASH;
            end
            ST_WASH, ST_RINSE, ST_DRY: begin
                if (abort)             state_d = ST_IDLE;
                else if (!door_closed) state_d = ST_FAULT;
                else if (advance)      state_d = next_phase(state_q);
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: begin
                if (abort) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            water_q     <= 1'b0;
            detergent_q <= 1'b0;
            spin_q      <= 1'b0;
            door_lock_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            water_q     <= ((state_d == ST_WASH) || (state_d == ST_RINSE)) && !paused_now;
            detergent_q <= (state_d == ST_WASH) && !paused_now;
            spin_q      <= (state_d == ST_DRY) && !paused_now;
            door_lock_q <= is_active(state_d);
            busy_q      <= is_active(state_d);
            done_q      <= (state_d == ST_DONE);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign water     = water_q;
    assign detergent = detergent_q;
    assign spin      = spin_q;
    assign door_lock = door_lock_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Self-checking bench: directed programme scenarios plus randomized traffic,
// compared every cycle against a minute-level behavioural model.
module tb_wash_cycle_sequencer;

    localparam int TW = 7;
    localparam int EL_MAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst, tick_min, start, pause, abort, door_closed;
    logic water, detergent, spin, door_lock, busy, done, fault;
    logic [2:0]    phase;
    logic [TW-1:0] elapsed;
    logic s_water, s_detergent, s_spin, s_door_lock, s_busy, s_done, s_fault;
    logic [2:0]    s_phase;
    logic [TW-1:0] s_elapsed;

    int n_total = 0;
    int n_pass  = 0;

    // model: programme position in minutes, indexed by phase code
    int dur[6] = '{0, 3, 2, 2, 0, 0};
    int m_st, m_pc, m_el;
    bit m_paused;

    wash_cycle_sequencer #(.TIMER_W(TW), .WASH_MIN(3), .RINSE_MIN(2), .DRY_MIN(2)) dut (
        .clk(clk), .rst(rst), .tick_min(tick_min), .start(start), .pause(pause),
        .abort(abort), .door_closed(door_closed), .water(water), .detergent(detergent),
        .spin(spin), .door_lock(door_lock), .busy(busy), .done(done), .fault(fault),
        .phase(phase), .elapsed(elapsed)
    );

    wash_cycle_sequencer #(.TIMER_W(TW), .WASH_MIN(100), .RINSE_MIN(100), .DRY_MIN(100)) dut_sat (
        .clk(clk), .rst(rst), .tick_min(tick_min), .start(start), .pause(pause),
        .abort(abort), .door_closed(door_closed), .water(s_water), .detergent(s_detergent),
        .spin(s_spin), .door_lock(s_door_lock), .busy(s_busy), .done(s_done), .fault(s_fault),
        .phase(s_phase), .elapsed(s_elapsed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit tk, input bit st, input bit pa,
                              input bit ab, input bit dc);
        bit act;
        int nst;
        if (r) begin
            m_st = 0; m_pc = 0; m_el = 0; m_paused = 0;
            return;
        end
        act = (m_st >= 1) && (m_st <= 3);
        nst = m_st;
        if (m_st == 0) begin
            if (st && dc) begin nst = 1; m_pc = 0; m_el = 0; end
        end else if (act) begin
            if (ab)       nst = 0;
            else if (!dc) nst = 5;
            else if (!pa && tk) begin
                if (m_el < EL_MAX) m_el++;
                m_pc++;
                if (m_pc == dur[m_st]) begin m_pc = 0; nst = m_st + 1; end
            end
        end else if (m_st == 4) begin
            nst = 0;
        end else if (ab) begin
            nst = 0;
        end
        m_paused = act && pa;
        m_st = nst;
    endtask

    task automatic check_all();
        bit a;
        a = (m_st >= 1) && (m_st <= 3);
        check("phase",     32'(phase),     32'(m_st));
        check("elapsed",   32'(elapsed),   32'(m_el));
        check("water",     32'(water),     32'((m_st == 1 || m_st == 2) && !m_paused));
        check("detergent", 32'(detergent), 32'((m_st == 1) && !m_paused));
        check("spin",      32'(spin),      32'((m_st == 3) && !m_paused));
        check("door_lock", 32'(door_lock), 32'(a));
        check("busy",      32'(busy),      32'(a));
        check("done",      32'(done),      32'(m_st == 4));
        check("fault",     32'(fault),     32'(m_st == 5));
    endtask

    task automatic step(input bit r, input bit tk, input bit st, input bit pa,
                        input bit ab, input bit dc);
        rst = r; tick_min = tk; start = st; pause = pa; abort = ab; door_closed = dc;
        @(posedge clk);
        model_step(r, tk, st, pa, ab, dc);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit pa, input bit dc);
        for (int i = 0; i < n; i++) step(0, 0, 0, pa, 0, dc);
    endtask

    task automatic tick_gap(input int n, input bit pa);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, pa, 0, 1);
            idle(4, pa, 1);
        end
    endtask

    initial begin
        bit dc_r, pa_r, tk_r, st_r, ab_r, r_r;
        rst = 1; tick_min = 0; start = 0; pause = 0; abort = 0; door_closed = 1;
        m_st = 0; m_pc = 0; m_el = 0; m_paused = 0;

        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        idle(2, 0, 1);

        // full programme: 3 + 2 + 2 ticks
        step(0, 0, 1, 0, 0, 1);
        check("start_water", 32'(water), 32'd1);
        idle(2, 0, 1);
        for (int t = 1; t <= 7; t++) begin
            check("plan_phase", 32'(phase), (t <= 3) ? 32'd1 : ((t <= 5) ? 32'd2 : 32'd3));
            step(0, 1, 0, 0, 0, 1);
            if (t < 7) idle(4, 0, 1);
        end
        check("plan_done", 32'(done), 32'd1);
        check("plan_unlock", 32'(door_lock), 32'd0);
        check("plan_elapsed", 32'(elapsed), 32'd7);
        step(0, 0, 0, 0, 0, 1);
        check("plan_done_once", 32'(done), 32'd0);
        idle(2, 0, 1);

        // start with the door open is ignored
        step(0, 0, 1, 0, 0, 0);
        check("open_start_phase", 32'(phase), 32'd0);
        idle(2, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        idle(1, 0, 1);

        // pause in RINSE
        tick_gap(3, 0);
        tick_gap(1, 0);
        idle(1, 1, 1);
        tick_gap(4, 1);
        check("pause_water", 32'(water), 32'd0);
        check("pause_elapsed", 32'(elapsed), 32'd4);
        idle(1, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        check("pause_to_dry", 32'(phase), 32'd3);
        step(0, 0, 0, 0, 1, 1);
        idle(2, 0, 1);

        // door opens in WASH at elapsed=2
        step(0, 0, 1, 0, 0, 1);
        tick_gap(2, 0);
        step(0, 0, 0, 0, 0, 0);
        check("fault_phase", 32'(phase), 32'd5);
        check("fault_elapsed", 32'(elapsed), 32'd2);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        idle(2, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        check("fault_cleared", 32'(fault), 32'd0);
        idle(2, 0, 1);

        // abort coinciding with a tick in DRY
        step(0, 0, 1, 0, 0, 1);
        tick_gap(5, 0);
        step(0, 1, 0, 0, 1, 1);
        check("abort_elapsed", 32'(elapsed), 32'd5);
        idle(3, 0, 1);

        // reset mid-WASH, then a full normal programme
        step(0, 0, 1, 0, 0, 1);
        tick_gap(1, 0);
        step(1, 0, 0, 0, 0, 1);
        check("rst_lock", 32'(door_lock), 32'd0);
        step(0, 0, 1, 0, 0, 1);
        tick_gap(7, 0);
        idle(2, 0, 1);

        // elapsed saturation on the long-duration instance
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 130; i++) begin
            step(0, 1, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 1);
        end
        check("sat_elapsed", 32'(s_elapsed), 32'(EL_MAX));
        check("sat_phase", 32'(s_phase), 32'd2);
        check("sat_water", 32'(s_water), 32'd1);
        step(1, 0, 0, 0, 0, 1);

        // randomized traffic
        dc_r = 1; pa_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if (dc_r && ($urandom_range(0, 79) == 0)) dc_r = 0;
            else if (!dc_r && ($urandom_range(0, 3) == 0)) dc_r = 1;
            if ($urandom_range(0, 14) == 0) pa_r = !pa_r;
            tk_r = ($urandom_range(0, 2) == 0);
            st_r = ($urandom_range(0, 9) == 0);
            ab_r = ($urandom_range(0, 59) == 0);
            r_r  = ($urandom_range(0, 499) == 0);
            step(r_r, tk_r, st_r, pa_r, ab_r, dc_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
